ex_div: RTL and testbench
=========================

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port start, input, 1: the EX stage holds a valid divide/remainder instruction.
REQ-005 Port op, input, 2: operation select; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 Port rs1, input, XLEN: dividend.
REQ-007 Port rs2, input, XLEN: divisor.
REQ-008 Port flush, input, 1: kill the in-flight operation.
REQ-009 Port stall_in, input, 1: stall bit for the EX stage from the pipeline controller.
REQ-010 Port stall_req, output, 1: stall request to the pipeline controller (EX-stage request bit).
REQ-011 Port result, output, XLEN: quotient or remainder.
REQ-012 Port result_valid, output, 1: result holds the completed value.

Function
REQ-013 The block SHALL implement three states: IDLE, BUSY, DONE.
REQ-014 IDLE with start=1 and flush=0 SHALL do the following on the next edge:
- latch op and operands;
- load the iteration counter with XLEN;
- enter BUSY, or enter DONE directly for a special case (REQ-019, REQ-020).
REQ-015 stall_req SHALL be combinational: (IDLE & start & ~flush) | BUSY.
- stall_req is 0 in DONE.
- stall_req is 0 whenever flush=1.
REQ-016 BUSY SHALL produce one quotient bit per cycle by restoring shift-subtract on unsigned magnitudes.
- The partial remainder is XLEN+1 bits wide.
- The counter decrements by 1 each cycle.
- The cycle in which the counter reaches 1 transitions to DONE.
REQ-017 Signed ops (DIV, REM) SHALL divide absolute values, then fix signs:
- quotient is negated iff operand signs differ;
- remainder takes the sign of the dividend.
REQ-018 Normal latency SHALL be fixed: start seen in cycle 0, BUSY for cycles 1..XLEN, result_valid=1 from cycle XLEN+1.
REQ-019 Divisor zero SHALL skip BUSY.
- Quotient is all ones for both DIV and DIVU.
- Remainder equals rs1.
- result_valid=1 in cycle 1.
REQ-020 Signed overflow (DIV/REM with rs1=most-negative, rs2=-1) SHALL skip BUSY.
- Quotient equals rs1.
- Remainder equals 0.
- result_valid=1 in cycle 1.
REQ-021 DONE SHALL hold result and result_valid stable while stall_in=1.
- Holding applies when a later stage stalls the pipeline.
- Exit to IDLE occurs on the first edge with stall_in=0.
REQ-022 start SHALL be ignored in BUSY and DONE.
- The EX input still holds the same instruction in those states.
- This prevents re-issue of the instruction.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge and clear result_valid.
- flush takes priority over start, counter expiry and stall_in.
REQ-024 result SHALL change only on the edge entering DONE and SHALL otherwise retain its value.
REQ-025 result_valid SHALL be 1 exactly while the block is in DONE.

Reset
REQ-026 rst_n=0 SHALL immediately force the following, independent of clk:
- state IDLE, counter 0;
- result 0, result_valid 0, stall_req 0 (subject to REQ-015 after release);
- internal operand and remainder registers 0.
REQ-027 Reset asserted mid-BUSY SHALL abandon the operation; no result is produced after release.
REQ-028 After rst_n rises, the first start SHALL be accepted on the next clk edge.

Verification
REQ-029 DIVU: rs1=100, rs2=7, stall_in=0 -> stall_req=1 for cycles 0..32, result=14 with result_valid=1 in cycle 33, IDLE in cycle 34.
REQ-030 REM: rs1=-100 (0xFFFFFF9C), rs2=7 -> result=0xFFFFFFFE (-2); DIV on same operands -> 0xFFFFFFF2 (-14).
REQ-031 DIV with rs2=0, rs1=5 -> stall_req=1 in cycle 0 only, result=0xFFFFFFFF in cycle 1; REMU with rs2=0 -> result=5.
REQ-032 DIV with rs1=0x80000000, rs2=0xFFFFFFFF -> result=0x80000000 in cycle 1; REM -> 0.
REQ-033 stall_in=1 held for 5 cycles after DONE entry -> result and result_valid unchanged for 5 cycles, start ignored, IDLE one cycle after stall_in falls.
REQ-034 flush at BUSY cycle 10, and separately rst_n=0 at BUSY cycle 10 -> both give IDLE, stall_req=0, result_valid=0; the next start completes correctly with full XLEN+1 latency.

Source files
------------

// File: rtl/ex_div.sv
// Iterative divider for the EX stage: DIV/DIVU/REM/REMU via restoring shift-subtract, one quotient bit per cycle.
// Latency XLEN+1 cycles (1 for divide-by-zero and signed overflow); holds the stage via stall_req and holds DONE while stall_in.
module ex_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  input  logic            stall_in,
  output logic            stall_req,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_signed, rs1_neg, rs2_neg, div_zero, sgn_ovf, special, accept, last_step;
  logic [XLEN-1:0]   mag1, mag2, special_res, quo_step, raw_res, fixed_res;
  logic [XLEN+1:0]   shifted;
  logic [XLEN:0]     rem_step;
  logic              q_bit;

  assign is_signed = ~op[0];
  assign rs1_neg   = is_signed & rs1[XLEN-1];
  assign rs2_neg   = is_signed & rs2[XLEN-1];
  assign mag1      = rs1_neg ? -rs1 : rs1;
  assign mag2      = rs2_neg ? -rs2 : rs2;
  assign div_zero  = (rs2 == '0);
  assign sgn_ovf   = is_signed & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
  assign special   = div_zero | sgn_ovf;
  assign accept    = (state_q == IDLE) & start & ~flush;
  assign last_step = (state_q == BUSY) & (cnt_q == CW'(1));

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op[1] ? rs1 : '1;
    else          special_res = op[1] ? '0  : rs1;
  end

  // rem_q[XLEN] stays 0 (remainder < divisor); widening keeps the compare exact
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign q_bit     = (shifted >= {2'b00, dvs_q});
  assign rem_step  = q_bit ? (XLEN+1)'(shifted - {2'b00, dvs_q}) : shifted[XLEN:0];
  assign quo_step  = {quo_q[XLEN-2:0], q_bit};
  assign raw_res   = op_q[1] ? rem_step[XLEN-1:0] : quo_step;
  assign fixed_res = neg_q ? -raw_res : raw_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = special ? DONE : BUSY;
      BUSY:    if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    if (!stall_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    stall_req    = ~flush & (((state_q == IDLE) & start) | (state_q == BUSY));
    result_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (accept) begin
      cnt_d = CW'(XLEN);
      op_d  = op;
      neg_d = op[1] ? rs1_neg : (rs1_neg ^ rs2_neg);
      quo_d = mag1;
      dvs_d = mag2;
      rem_d = '0;
      if (special) result_d = special_res;
    end else if ((state_q == BUSY) && !flush) begin
      cnt_d = cnt_q - CW'(1);
      quo_d = quo_step;
      rem_d = rem_step;
      if (last_step) result_d = fixed_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: scoreboard of expected results, one task per scenario.
module tb_ex_div;

  localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, stall_in;
  logic [1:0]  op;
  logic [31:0] rs1, rs2, result;
  logic        stall_req, result_valid;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sbq[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  ex_div #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall_in(stall_in), .stall_req(stall_req),
    .result(result), .result_valid(result_valid)
  );

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
    case (o)
      DIV:     return sa / sbv;
      DIVU:    return a / b;
      REM:     return sa % sbv;
      default: return a % b;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, hold start as the EX stage would, and check latency, stall_req and result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input int hold, input string name);
    int          cyc;
    bit          bad_stall;
    logic [31:0] exp;
    op = o; rs1 = a; rs2 = b; start = 1'b1; stall_in = (hold > 0);
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      failures++;
      $display("FAIL %s stall_req_c0 got=%b want=1", name, stall_req);
    end
    sbq.push_back(model(o, a, b));
    cyc = 0;
    bad_stall = 0;
    do begin
      tick();
      cyc++;
      if (result_valid !== 1'b1 && stall_req !== 1'b1) bad_stall = 1;
    end while (result_valid !== 1'b1 && cyc < 100);
    exp = sbq.pop_front();
    checks++;
    if (cyc != exp_lat) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d (valid=%b)", name, cyc, exp_lat, result_valid);
    end
    checks++;
    if (bad_stall || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL %s stall_req busy_drop=%0d done_val=%b want busy=1 done=0", name, bad_stall, stall_req);
    end
    checks++;
    if (result !== exp) begin
      failures++;
      $display("FAIL %s result got=%h want=%h", name, result, exp);
    end
    rs1 = ~a;
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (result_valid !== 1'b1 || result !== exp) begin
        failures++;
        $display("FAIL %s hold%0d valid=%b result=%h want valid=1 result=%h", name, i, result_valid, result, exp);
      end
    end
    stall_in = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (result_valid !== 1'b0 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after valid=%b stall_req=%b want 0 0", name, result_valid, stall_req);
    end
    last_res = exp;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; stall_in = 1'b0;
    op = DIV; rs1 = '0; rs2 = '0;
    #2;
    checks++;
    if (result !== 32'h0 || result_valid !== 1'b0 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL reset result=%h valid=%b stall_req=%b want 0 0 0", result, result_valid, stall_req);
    end
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_divu;
    run_op(DIVU, 32'd100, 32'd7, 33, 0, "divu_100_7");
    run_op(DIVU, 32'hFFFF_FFFF, 32'd1, 33, 0, "divu_max_1");
    run_op(DIVU, 32'd3, 32'd10, 33, 0, "divu_small");
  endtask

  task automatic test_signed;
    run_op(REM, 32'hFFFF_FF9C, 32'd7, 33, 0, "rem_m100_7");
    run_op(DIV, 32'hFFFF_FF9C, 32'd7, 33, 0, "div_m100_7");
    run_op(DIV, 32'd100, 32'hFFFF_FFF9, 33, 0, "div_100_m7");
    run_op(REM, 32'd100, 32'hFFFF_FFF9, 33, 0, "rem_100_m7");
  endtask

  task automatic test_div_zero;
    run_op(DIV, 32'd5, 32'd0, 1, 0, "div_by0");
    run_op(REMU, 32'd5, 32'd0, 1, 0, "remu_by0");
    run_op(DIVU, 32'h1234_5678, 32'd0, 1, 0, "divu_by0");
    run_op(REM, 32'hFFFF_FFF0, 32'd0, 1, 0, "rem_by0");
  endtask

  task automatic test_overflow;
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, "div_ovf");
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, "rem_ovf");
    run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0, "divu_no_ovf");
  endtask

  task automatic test_stall_hold;
    run_op(DIVU, 32'd1000, 32'd3, 33, 5, "stall_hold");
    run_op(DIV, 32'd9, 32'd0, 1, 3, "stall_hold_by0");
  endtask

  task automatic test_flush;
    op = DIV; rs1 = 32'd7; rs2 = 32'd0; start = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle stall_req got=%b want=0", stall_req);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || result !== last_res) begin
      failures++;
      $display("FAIL flush_idle valid=%b result=%h want 0 %h", result_valid, result, last_res);
    end
    flush = 1'b0; start = 1'b0;
    tick();
    op = DIVU; rs1 = 32'd12345; rs2 = 32'd11; start = 1'b1;
    repeat (10) tick();
    flush = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy stall_req got=%b want=0", stall_req);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || stall_req !== 1'b0 || result !== last_res) begin
      failures++;
      $display("FAIL flush_busy valid=%b stall_req=%b result=%h want 0 0 %h", result_valid, stall_req, result, last_res);
    end
    run_op(DIVU, 32'd12345, 32'd11, 33, 0, "after_flush");
  endtask

  task automatic test_reset_busy;
    bit seen;
    op = REM; rs1 = 32'hFFFF_0000; rs2 = 32'd13; start = 1'b1;
    repeat (10) tick();
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 32'h0 || result_valid !== 1'b0 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy result=%h valid=%b stall_req=%b want 0 0 0", result, result_valid, stall_req);
    end
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (result_valid !== 1'b0 || stall_req !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_busy stray_activity got=1 want=0");
    end
    run_op(REM, 32'hFFFF_0000, 32'd13, 33, 0, "after_reset");
  endtask

  task automatic test_back_to_back;
    logic [1:0]  o;
    logic [31:0] a, b;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 5) b = 32'h0;
      if (i == 8) begin o = DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      lat = (b == 32'h0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      run_op(o, a, b, lat, 0, $sformatf("b2b%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_stall_hold();
    test_flush();
    test_reset_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
